// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: two-stage pipelined SECDED (extended Hamming) decoder
// with valid/ready handshake, optional single-bit correction and saturating
// error statistics. Codeword bit0 is overall even parity, bits 1..N are the
// Hamming positions (power-of-2 positions are parity, data fills the rest).
module secded_stream_decoder #(
    parameter int DATA_W  = 4,
    parameter int CORRECT = 1,
    parameter int CNT_W   = 16,
    // smallest P with 2^P >= DATA_W+P+1, valid for DATA_W 4..120
    localparam int P  = (DATA_W <= 4)  ? 3 :
                        (DATA_W <= 11) ? 4 :
                        (DATA_W <= 26) ? 5 :
                        (DATA_W <= 57) ? 6 : 7,
    localparam int N  = DATA_W + P,
    localparam int CW = N + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_single,
    output logic              out_double,
    output logic [P-1:0]      out_syndrome,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    // stage enables
    logic              w_e1;
    logic              w_e2;

    // stage 1 state
    logic              r_s1_valid;
    logic [CW-1:0]     r_s1_code;
    logic [P-1:0]      r_s1_syn;
    logic              r_s1_ov;

    // stage 2 state (drives the output fields)
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_single;
    logic              r_out_double;
    logic [P-1:0]      r_out_syn;

    // statistics
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    // combinational decode results
    logic [P-1:0]      w_syn;
    logic              w_ov;
    logic              w_single;
    logic              w_double;
    logic [CW-1:0]     w_fix_code;
    logic [DATA_W-1:0] w_data;
    logic              w_out_hs;

    assign w_e2     = !r_out_valid || out_ready;
    assign w_e1     = !r_s1_valid || w_e2;
    assign in_ready = w_e1;
    assign w_out_hs = r_out_valid && out_ready;

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_single   = r_out_single;
    assign out_double   = r_out_double;
    assign out_syndrome = r_out_syn;
    assign corr_cnt     = r_corr_cnt;
    assign uncorr_cnt   = r_uncorr_cnt;

    // syndrome = XOR of indices of set Hamming positions; ov = parity of whole word
    always_comb begin
        w_syn = '0;
        for (int unsigned pos = 1; pos <= N; pos++) begin
            if (in_code[pos]) begin
                w_syn = w_syn ^ P'(pos);
            end
        end
        w_ov = ^in_code;
    end

    // stage 1 register: raw codeword plus its syndrome and overall parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_ov    <= 1'b0;
        end else if (w_e1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_syn;
                r_s1_ov   <= w_ov;
            end
        end
    end

    // classify the stage-1 word and apply single-bit correction when enabled
    always_comb begin
        w_single   = 1'b0;
        w_double   = 1'b0;
        w_fix_code = r_s1_code;
        if (r_s1_ov) begin
            if (r_s1_syn == '0) begin
                w_single = 1'b1;
            end else if (int'(r_s1_syn) <= N) begin
                w_single = 1'b1;
                if (CORRECT != 0) begin
                    w_fix_code[r_s1_syn] = ~r_s1_code[r_s1_syn];
                end
            end else begin
                w_double = 1'b1;
            end
        end else if (r_s1_syn != '0) begin
            w_double = 1'b1;
        end
    end

    // gather payload bits from the non-power-of-2 positions, ascending
    always_comb begin
        int unsigned k;
        w_data = '0;
        k      = 0;
        for (int unsigned pos = 3; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w_data[k] = w_fix_code[pos];
                k         = k + 1;
            end
        end
    end

    // stage 2 register: output fields, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_single <= 1'b0;
            r_out_double <= 1'b0;
            r_out_syn    <= '0;
        end else if (w_e2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= w_data;
                r_out_single <= w_single;
                r_out_double <= w_double;
                r_out_syn    <= r_s1_syn;
            end
        end
    end

    // saturating error counters, bumped on output handshake; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (clear_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_out_single && (r_corr_cnt != '1)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (r_out_double && (r_uncorr_cnt != '1)) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Scoreboard bench for secded_stream_decoder. Three instances share all inputs:
// the default one (CORRECT=1, CNT_W=16), a detect-only one (CORRECT=0) and a
// narrow-counter one (CNT_W=2). Expected results are queued at input handshake.
module tb_secded_stream_decoder;

    typedef struct {
        logic [3:0] data;
        logic [3:0] raw;
        logic       single;
        logic       dbl;
        logic [2:0] syn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_code = '0;
    logic       out_ready = 1'b1;
    logic       clear_cnt = 1'b0;

    logic       in_ready, out_valid, out_single, out_double;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic       nc_in_ready, nc_out_valid, nc_out_single, nc_out_double;
    logic [3:0] nc_out_data;
    logic [2:0] nc_out_syndrome;
    logic [15:0] nc_corr_cnt, nc_uncorr_cnt;

    logic       st_in_ready, st_out_valid, st_out_single, st_out_double;
    logic [3:0] st_out_data;
    logic [2:0] st_out_syndrome;
    logic [1:0] st_corr_cnt, st_uncorr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q[$];
    logic [15:0] m_corr = '0, m_uncorr = '0;
    logic [1:0]  m_st_corr = '0, m_st_uncorr = '0;
    bit          saw_backpressure = 0;
    bit          rand_ready = 0;

    always #5 clk = ~clk;

    secded_stream_decoder #(.DATA_W(4), .CORRECT(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_single(out_single), .out_double(out_double),
        .out_syndrome(out_syndrome), .clear_cnt(clear_cnt),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    secded_stream_decoder #(.DATA_W(4), .CORRECT(0), .CNT_W(16)) dut_nc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
        .in_code(in_code), .out_valid(nc_out_valid), .out_ready(out_ready),
        .out_data(nc_out_data), .out_single(nc_out_single), .out_double(nc_out_double),
        .out_syndrome(nc_out_syndrome), .clear_cnt(clear_cnt),
        .corr_cnt(nc_corr_cnt), .uncorr_cnt(nc_uncorr_cnt)
    );

    secded_stream_decoder #(.DATA_W(4), .CORRECT(1), .CNT_W(2)) dut_st (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(st_in_ready),
        .in_code(in_code), .out_valid(st_out_valid), .out_ready(out_ready),
        .out_data(st_out_data), .out_single(st_out_single), .out_double(st_out_double),
        .out_syndrome(st_out_syndrome), .clear_cnt(clear_cnt),
        .corr_cnt(st_corr_cnt), .uncorr_cnt(st_uncorr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hamming(7,4)+overall parity, data at positions 3,5,6,7
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c    = '0;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[1] = d[0] ^ d[1] ^ d[3];
        c[2] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = ^c[7:1];
        return c;
    endfunction

    function automatic exp_t model(input logic [7:0] c);
        exp_t e;
        logic [2:0] s;
        logic       ov;
        logic [7:0] f;
        s = '0;
        for (int i = 1; i < 8; i++) if (c[i]) s = s ^ 3'(i);
        ov = ^c;
        f  = c;
        e.single = ov;
        e.dbl    = !ov && (s != 0);
        if (ov && s != 0) f[s] = ~f[s];
        e.syn  = s;
        e.data = {f[7], f[6], f[5], f[3]};
        e.raw  = {c[7], c[6], c[5], c[3]};
        return e;
    endfunction

    function automatic exp_t mk(input logic [3:0] d, input logic [3:0] r,
                                input logic s, input logic db, input logic [2:0] sy);
        exp_t e;
        e.data = d; e.raw = r; e.single = s; e.dbl = db; e.syn = sy;
        return e;
    endfunction

    // present one word and wait (bounded) until it is accepted
    task automatic send(input logic [7:0] code, input exp_t e);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_code  = code;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    // output monitor and counter model, sampled on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_corr = '0; m_uncorr = '0; m_st_corr = '0; m_st_uncorr = '0;
            end else begin
                chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
                chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
                chk("sat_corr_cnt", 32'(st_corr_cnt), 32'(m_st_corr));
                chk("sat_uncorr_cnt", 32'(st_uncorr_cnt), 32'(m_st_uncorr));
                if (in_valid && !in_ready) saw_backpressure = 1;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", 32'(out_valid), 32'd0);
                    end else begin
                        e = q[0];
                        chk("out_data", 32'(out_data), 32'(e.data));
                        chk("out_single", 32'(out_single), 32'(e.single));
                        chk("out_double", 32'(out_double), 32'(e.dbl));
                        chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
                        chk("nc_out_valid", 32'(nc_out_valid), 32'd1);
                        chk("nc_out_data", 32'(nc_out_data), 32'(e.raw));
                        chk("nc_out_single", 32'(nc_out_single), 32'(e.single));
                        if (out_ready) begin
                            void'(q.pop_front());
                            if (!clear_cnt) begin
                                if (e.single) begin
                                    m_corr = m_corr + 16'd1;
                                    if (m_st_corr != 2'b11) m_st_corr = m_st_corr + 2'd1;
                                end
                                if (e.dbl) begin
                                    m_uncorr = m_uncorr + 16'd1;
                                    if (m_st_uncorr != 2'b11) m_st_uncorr = m_st_uncorr + 2'd1;
                                end
                            end
                        end
                    end
                end
                if (clear_cnt) begin
                    m_corr = '0; m_uncorr = '0; m_st_corr = '0; m_st_uncorr = '0;
                end
            end
        end
    end

    // random sink backpressure while enabled
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c;
        logic [3:0] d;
        int b0, b1, nflip;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_flags", {30'd0, out_single, out_double}, 32'd0);
        chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
        chk("rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // directed vectors
        send(8'hAA, mk(4'hB, 4'hB, 1'b0, 1'b0, 3'd0));
        send(8'hEA, mk(4'hB, 4'hF, 1'b1, 1'b0, 3'd6));
        send(8'hE2, mk(4'hE, 4'hE, 1'b0, 1'b1, 3'd5));
        send(8'hAB, mk(4'hB, 4'hB, 1'b1, 1'b0, 3'd0));
        drain();
        chk("dir_corr_cnt", 32'(corr_cnt), 32'd2);
        chk("dir_uncorr_cnt", 32'(uncorr_cnt), 32'd1);

        // 8 back-to-back words, sink stalled for cycles 3..6
        saw_backpressure = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = 4'(i * 3 + 1);
                    c = enc(d);
                    if (i % 3 == 1) c[i % 8] = ~c[i % 8];
                    send(c, model(c));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_backpressure", 32'(saw_backpressure), 32'd1);

        // random stream with random sink backpressure and 0/1/2-bit errors
        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            d     = 4'($urandom_range(0, 15));
            c     = enc(d);
            nflip = $urandom_range(0, 2);
            b0    = $urandom_range(0, 7);
            b1    = (b0 + $urandom_range(1, 7)) % 8;
            if (nflip >= 1) c[b0] = ~c[b0];
            if (nflip == 2) c[b1] = ~c[b1];
            send(c, model(c));
        end
        rand_ready = 0;
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // clear, then five single errors saturate the 2-bit counter
        clear_cnt = 1'b1;
        @(posedge clk); #1 clear_cnt = 1'b0;
        chk("clear_cnt", {corr_cnt, uncorr_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            c = enc(4'(i + 5));
            c[(i % 7) + 1] = ~c[(i % 7) + 1];
            send(c, model(c));
        end
        drain();
        chk("sat_corr_3", 32'(st_corr_cnt), 32'd3);
        chk("full_corr_5", 32'(corr_cnt), 32'd5);

        // clear coincident with an output handshake of a single-error word
        out_ready = 1'b0;
        c = enc(4'h9);
        c[0] = ~c[0];
        send(c, model(c));
        repeat (2) @(posedge clk);
        #1;
        chk("held_valid", 32'(out_valid), 32'd1);
        clear_cnt = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear_cnt = 1'b0;
        chk("clear_hs_corr", 32'(corr_cnt), 32'd0);
        chk("clear_hs_sat", 32'(st_corr_cnt), 32'd0);
        drain();

        // reset with two words in flight
        send(enc(4'h3), model(enc(4'h3)));
        send(enc(4'hC), model(enc(4'hC)));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale_word", 32'(out_valid), 32'd0);
        end
        send(8'hAA, mk(4'hB, 4'hB, 1'b0, 1'b0, 3'd0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
